// File: rtl/game_pkg.sv
// Shared game definitions: scroller FSM states, default level geometry and
// screen codes consumed by the display logic.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_DONE   = 2'd3
  } scroll_state_e;

  localparam int DEF_TICK_DIV  = 250000;
  localparam int DEF_LEVEL_LEN = 2048;
  localparam int DEF_REWIND_PX = 64;

  localparam logic [2:0] SCR_TITLE     = 3'd0;
  localparam logic [2:0] SCR_PLAY      = 3'd1;
  localparam logic [2:0] SCR_LEVEL_UP  = 3'd2;
  localparam logic [2:0] SCR_WORLD_UP  = 3'd3;
  localparam logic [2:0] SCR_GAME_OVER = 3'd4;
  localparam logic [2:0] SCR_WIN       = 3'd5;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle scroll tick; the phase is held while
// disabled so a pause resumes mid-period rather than restarting it.
module tick_prescaler #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/level_scroller.sv
// Level scroll position generator; raises level_complete at the end of the
// level and holds it until the game FSM moves to a new level or world.
import game_pkg::*;

module level_scroller #(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int LEVEL_LEN = DEF_LEVEL_LEN,
  parameter int REWIND_PX = DEF_REWIND_PX,
  parameter int POS_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       level,
  input  logic [2:0]       world,
  input  logic             playerDisable,
  input  logic             resetSelect,
  input  logic             player_dead,
  output logic [POS_W-1:0] scroll_pos,
  output logic             scroll_tick,
  output logic             level_complete
);

  localparam logic [POS_W:0]   LEN_X = (POS_W + 1)'(LEVEL_LEN);
  localparam logic [POS_W-1:0] LEN_P = POS_W'(LEVEL_LEN);
  localparam logic [POS_W-1:0] RW_P  = POS_W'(REWIND_PX);

  scroll_state_e    state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             tick_q, tick_d;
  logic [2:0]       lvl_q, wld_q;
  logic             dead_q;

  logic             lw_change, dead_rise, adv_en, pre_clr, tick;
  logic [3:0]       step;
  logic [POS_W:0]   sum;
  logic [POS_W-1:0] rewound;

  assign lw_change = (level != lvl_q) || (world != wld_q);
  assign dead_rise = player_dead && !dead_q;
  // Only a cycle that could actually advance consumes prescaler phase.
  assign adv_en    = (state_q == ST_SCROLL) && !playerDisable && !player_dead &&
                     !resetSelect && !lw_change;
  assign pre_clr   = (state_q == ST_IDLE) || resetSelect || lw_change;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (adv_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  assign step    = {1'b0, world} + 4'd1;
  assign sum     = {1'b0, pos_q} + (POS_W + 1)'(step);
  assign rewound = (pos_q > RW_P) ? (pos_q - RW_P) : '0;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tick_d  = 1'b0;
    if (resetSelect || lw_change) begin
      state_d = ST_IDLE;
      pos_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pos_d = '0;
          if (!playerDisable) state_d = ST_SCROLL;
        end
        ST_SCROLL: begin
          if (dead_rise) pos_d = rewound;
          if (playerDisable || player_dead) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            tick_d = 1'b1;
            if (sum >= LEN_X) begin
              pos_d   = LEN_P;
              state_d = ST_DONE;
            end else begin
              pos_d = sum[POS_W-1:0];
            end
          end
        end
        ST_PAUSE: begin
          if (dead_rise) pos_d = rewound;
          if (!playerDisable && !player_dead) state_d = ST_SCROLL;
        end
        ST_DONE: begin
          pos_d = LEN_P;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      tick_q  <= 1'b0;
      lvl_q   <= '0;
      wld_q   <= '0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
      lvl_q   <= level;
      wld_q   <= world;
      dead_q  <= player_dead;
    end
  end

  assign scroll_pos     = pos_q;
  assign scroll_tick    = tick_q;
  assign level_complete = (state_q == ST_DONE);

endmodule

// File: tb/tb_level_scroller.sv
// Bench for level_scroller: table of speeds, directed corner sequences and
// random play compared cycle by cycle against a behavioural model.
module tb_level_scroller;

  localparam int TD  = 4;
  localparam int LEN = 20;
  localparam int RW  = 8;
  localparam int PW  = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    level = 3'd0;
  logic [2:0]    world = 3'd0;
  logic          pd = 1'b1;
  logic          rs = 1'b0;
  logic          dead = 1'b0;
  logic [PW-1:0] scroll_pos;
  logic          scroll_tick;
  logic          level_complete;

  level_scroller #(.TICK_DIV(TD), .LEVEL_LEN(LEN), .REWIND_PX(RW), .POS_W(PW)) dut (
    .clk            (clk),
    .rst            (rst),
    .level          (level),
    .world          (world),
    .playerDisable  (pd),
    .resetSelect    (rs),
    .player_dead    (dead),
    .scroll_pos     (scroll_pos),
    .scroll_tick    (scroll_tick),
    .level_complete (level_complete)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: level progress in pixels, a cycle counter that
  // produces a tick every TD running cycles, and simple mode flags.
  int       m_pos, m_phase;
  bit       m_started, m_paused, m_done, m_tick, m_dead;
  bit [2:0] m_lvl, m_wld;

  task automatic model_reset();
    m_pos = 0; m_phase = 0; m_started = 0; m_paused = 0;
    m_done = 0; m_tick = 0; m_dead = 0; m_lvl = 0; m_wld = 0;
  endtask

  task automatic model_step();
    bit lw, rise;
    lw   = (level != m_lvl) || (world != m_wld);
    rise = dead && !m_dead;
    m_tick = 0;
    if (rs || lw) begin
      m_started = 0; m_done = 0; m_pos = 0; m_phase = 0; m_paused = 0;
    end else if (!m_started) begin
      m_pos = 0; m_phase = 0;
      if (!pd) begin
        m_started = 1; m_paused = 0;
      end
    end else if (!m_done) begin
      if (rise) m_pos = (m_pos < RW) ? 0 : m_pos - RW;
      if (m_paused) begin
        if (!pd && !dead) m_paused = 0;
      end else if (pd || dead) begin
        m_paused = 1;
      end else begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          m_tick  = 1;
          m_pos   = m_pos + int'(world) + 1;
          if (m_pos >= LEN) begin
            m_pos  = LEN;
            m_done = 1;
          end
        end
      end
    end
    m_lvl  = level;
    m_wld  = world;
    m_dead = dead;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model_pos", int'(scroll_pos), m_pos);
    check("model_tick", int'(scroll_tick), int'(m_tick));
    check("model_lc", int'(level_complete), int'(m_done));
  endtask

  task automatic run_until_pos(input int target, input int bound, input string name);
    int i;
    i = 0;
    while (int'(scroll_pos) != target && i < bound) begin
      cyc();
      i++;
    end
    check(name, int'(scroll_pos), target);
  endtask

  typedef struct {
    logic [2:0] world;
    int         exp_ticks;
    int         first_pos;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int ticks, cnt, last;
    vecs[0] = '{3'd0, 20, 1};
    vecs[1] = '{3'd3, 5, 4};
    vecs[2] = '{3'd6, 3, 7};
    vecs[3] = '{3'd7, 3, 8};
    vecs[4] = '{3'd4, 4, 5};

    // Reset values and async reset mid-scroll
    model_reset();
    #1;
    check("rst_pos", int'(scroll_pos), 0);
    check("rst_tick", int'(scroll_tick), 0);
    check("rst_lc", int'(level_complete), 0);
    #11 rst = 1'b1;
    repeat (4) cyc();
    check("idle_disabled_pos", int'(scroll_pos), 0);
    pd = 1'b0;
    run_until_pos(12, 200, "reach_12");
    #2 rst = 1'b0;
    #1;
    check("async_rst_pos", int'(scroll_pos), 0);
    check("async_rst_lc", int'(level_complete), 0);
    check("async_rst_tick", int'(scroll_tick), 0);
    model_reset();
    pd = 1'b1;
    @(negedge clk) rst = 1'b1;
    repeat (4) cyc();
    check("post_rst_idle_pos", int'(scroll_pos), 0);
    pd = 1'b0;

    // Speed table; each world change also acknowledges the previous DONE
    for (int i = 0; i < 5; i++) begin
      world = vecs[i].world;
      if (i > 0) begin
        cyc();
        check("ack_world_lc", int'(level_complete), 0);
        check("ack_world_pos", int'(scroll_pos), 0);
      end
      ticks = 0; cnt = 0; last = 0;
      while (!level_complete && cnt < 400) begin
        cyc();
        cnt++;
        if (scroll_tick) begin
          ticks++;
          if (ticks == 1) begin
            check("first_tick_latency", cnt, TD + 1);
            check("first_step_pos", int'(scroll_pos), vecs[i].first_pos);
          end else begin
            check("tick_gap", cnt - last, TD);
          end
          last = cnt;
        end
      end
      check("ticks_to_done", ticks, vecs[i].exp_ticks);
      check("done_pos", int'(scroll_pos), LEN);
      check("done_lc", int'(level_complete), 1);
      if (vecs[i].world == 3'd0) begin
        ticks = 0;
        repeat (110) begin
          cyc();
          if (scroll_tick) ticks++;
        end
        check("done_hold_ticks", ticks, 0);
        check("done_hold_lc", int'(level_complete), 1);
        check("done_hold_pos", int'(scroll_pos), LEN);
      end
    end

    // Acknowledge by level change
    level = 3'd1;
    cyc();
    check("ack_level_lc", int'(level_complete), 0);
    check("ack_level_pos", int'(scroll_pos), 0);
    cnt = 0;
    while (!scroll_tick && cnt < 20) begin
      cyc();
      cnt++;
    end
    check("restart_latency", cnt, TD + 1);
    check("restart_pos", int'(scroll_pos), 5);

    // Death rewinds
    world = 3'd0; level = 3'd2;
    cyc();
    run_until_pos(10, 200, "reach_10");
    dead = 1'b1;
    cyc();
    check("rewind_from_10", int'(scroll_pos), 2);
    ticks = 0;
    repeat (20) begin
      cyc();
      if (scroll_tick) ticks++;
    end
    check("dead_no_ticks", ticks, 0);
    check("dead_pos_held", int'(scroll_pos), 2);
    dead = 1'b0;
    run_until_pos(3, 20, "resume_after_death");
    run_until_pos(5, 40, "reach_5");
    dead = 1'b1;
    cyc();
    check("rewind_floor", int'(scroll_pos), 0);
    dead = 1'b0;
    run_until_pos(18, 200, "reach_18");
    dead = 1'b1;
    repeat (50) cyc();
    check("rewind_once", int'(scroll_pos), 10);
    dead = 1'b0;

    // Pause keeps prescaler phase
    level = 3'd3;
    cyc();
    run_until_pos(9, 200, "reach_9_pause");
    cyc();
    cyc();
    pd = 1'b1;
    ticks = 0;
    repeat (41) begin
      cyc();
      if (scroll_tick) ticks++;
    end
    check("pause_no_ticks", ticks, 0);
    check("pause_pos", int'(scroll_pos), 9);
    pd = 1'b0;
    cyc();
    cnt = 0;
    while (!scroll_tick && cnt < 10) begin
      cyc();
      cnt++;
    end
    check("phase_kept", cnt, 2);

    // resetSelect mid-level
    level = 3'd4;
    cyc();
    run_until_pos(9, 200, "reach_9_rs");
    rs = 1'b1;
    cyc();
    rs = 1'b0;
    check("rs_pos", int'(scroll_pos), 0);
    check("rs_lc", int'(level_complete), 0);

    // resetSelect together with level change while DONE
    world = 3'd7;
    cnt = 0;
    while (!level_complete && cnt < 100) begin
      cyc();
      cnt++;
    end
    check("fast_done_lc", int'(level_complete), 1);
    rs = 1'b1; level = 3'd5;
    cyc();
    rs = 1'b0;
    check("rs_level_lc", int'(level_complete), 0);
    check("rs_level_pos", int'(scroll_pos), 0);

    // Random play against the model
    for (int k = 0; k < 4000; k++) begin
      if (pd ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0)) pd = ~pd;
      if (dead ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 39) == 0)) dead = ~dead;
      rs = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 149) == 0) level = 3'($urandom);
      if ($urandom_range(0, 149) == 0) world = 3'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
